hazard_forwarding_controller: RTL and testbench

Pipeline hazard controller for the five-stage RISC-V core. It keeps a shadow copy of the register-usage fields of the instructions in EX, MEM and WB. From that shadow it drives the 2-bit operand-select codes of the two EX-stage forwarding muxes. It also detects load-use hazards, inserts one bubble per hazard, honours branch flushes and data-memory wait states, and counts inserted load-use stalls.

---
 rtl/hazard_forwarding_controller.sv | 106 ++++++++++
 tb/tb_hazard_forwarding_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forwarding_controller.sv
// Shadows EX/MEM/WB register usage, decodes EX forwarding selects from registered state,
// and raises a one-cycle load-use stall/bubble; mem_wait freezes everything, flush kills ID.
module hazard_forwarding_controller (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [4:0]  id_rd,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        flush,
   input  logic        mem_wait,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic        stall,
   output logic        bubble,
   output logic [15:0] load_use_count
);

   typedef struct packed {
      logic       vld;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       uses_rs1;
      logic       uses_rs2;
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
   } entry_t;

   entry_t      ex_q, mem_q, wb_q;
   entry_t      ex_d, mem_d, wb_d;
   entry_t      id_entry;
   logic [15:0] cnt_q, cnt_d;
   logic        load_use;

   function automatic logic writes(entry_t e, logic [4:0] r);
      return e.vld && e.reg_write && (e.rd != 5'd0) && (e.rd == r);
   endfunction

   // MEM is checked first so the youngest producer wins.
   function automatic logic [1:0] fwd_sel(entry_t ex, entry_t mem, entry_t wb,
                                          logic [4:0] r, logic used);
      logic [1:0] sel;
      sel = 2'b00;
      if (ex.vld && used) begin
         if (writes(mem, r))
            sel = 2'b10;
         else if (writes(wb, r))
            sel = 2'b01;
      end
      return sel;
   endfunction

   assign id_entry = '{vld: id_valid, rs1: id_rs1, rs2: id_rs2,
                       uses_rs1: id_uses_rs1, uses_rs2: id_uses_rs2,
                       rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

   assign fwd_a = fwd_sel(ex_q, mem_q, wb_q, ex_q.rs1, ex_q.uses_rs1);
   assign fwd_b = fwd_sel(ex_q, mem_q, wb_q, ex_q.rs2, ex_q.uses_rs2);

   assign load_use = id_valid && ex_q.vld && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_q.rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_q.rd)));

   // Gated by rst so both drop the moment reset asserts, whatever the inputs do.
   assign stall  = !rst && (mem_wait || (load_use && !flush));
   assign bubble = !rst && !mem_wait && (flush || load_use);

   assign load_use_count = cnt_q;

   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      cnt_d = cnt_q;
      if (!mem_wait) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         ex_d  = (flush || load_use) ? '0 : id_entry;
         if (!flush && load_use && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
         cnt_q <= cnt_d;
      end
   end

   logic unused_wb_fields;
   assign unused_wb_fields = ^{wb_q.rs1, wb_q.rs2, wb_q.uses_rs1, wb_q.uses_rs2, wb_q.mem_read};

endmodule

// File: tb/tb_hazard_forwarding_controller.sv
// Directed bench for hazard_forwarding_controller with an instruction-level reference model.
module tb_hazard_forwarding_controller;

   typedef struct packed {
      logic       v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
   } ins_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush, mem_wait;
   ins_t        cur;
   logic        id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [1:0]  fwd_a, fwd_b;
   logic        stall, bubble;
   logic [15:0] load_use_count;

   int   checks = 0;
   int   failures = 0;
   logic preload = 1'b0;

   assign id_valid     = cur.v;
   assign id_rs1       = cur.rs1;
   assign id_rs2       = cur.rs2;
   assign id_uses_rs1  = cur.u1;
   assign id_uses_rs2  = cur.u2;
   assign id_rd        = cur.rd;
   assign id_reg_write = cur.rw;
   assign id_mem_read  = cur.mr;

   hazard_forwarding_controller dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .mem_wait(mem_wait), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall),
      .bubble(bubble), .load_use_count(load_use_count)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   function automatic ins_t alu(int rd, int rs1, int rs2);
      ins_t i;
      i = '0;
      i.v = 1'b1; i.rd = rd[4:0]; i.rs1 = rs1[4:0]; i.rs2 = rs2[4:0];
      i.u1 = 1'b1; i.u2 = 1'b1; i.rw = 1'b1;
      return i;
   endfunction

   function automatic ins_t ld(int rd, int rs1);
      ins_t i;
      i = '0;
      i.v = 1'b1; i.rd = rd[4:0]; i.rs1 = rs1[4:0]; i.u1 = 1'b1; i.rw = 1'b1; i.mr = 1'b1;
      return i;
   endfunction

   // ---------------- reference model: the in-flight instructions themselves ----------------
   ins_t m_ex, m_mem, m_wb;
   int   m_cnt;

   function automatic logic produces(ins_t p, logic [4:0] r);
      return p.v && p.rw && (p.rd != 5'd0) && (p.rd == r);
   endfunction

   // Search older instructions youngest-first; distance 1 -> EX/MEM, distance 2 -> MEM/WB.
   function automatic logic [1:0] exp_fwd(ins_t c, logic [4:0] r, logic used);
      ins_t older [2];
      older[0] = m_mem;
      older[1] = m_wb;
      if (!c.v || !used) return 2'b00;
      for (int k = 0; k < 2; k++)
         if (produces(older[k], r)) return (k == 0) ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   function automatic logic m_lu();
      logic hit;
      hit = (cur.u1 && cur.rs1 == m_ex.rd) || (cur.u2 && cur.rs2 == m_ex.rd);
      return cur.v && m_ex.v && m_ex.mr && (m_ex.rd != 5'd0) && hit;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ex <= '0; m_mem <= '0; m_wb <= '0; m_cnt <= 0;
      end else if (preload) begin
         m_cnt <= 65533;
      end else if (!mem_wait) begin
         m_wb  <= m_mem;
         m_mem <= m_ex;
         m_ex  <= (flush || m_lu()) ? '0 : cur;
         if (m_lu() && !flush && m_cnt < 65535) m_cnt <= m_cnt + 1;
      end
   end

   always @(negedge clk) begin
      chk("cyc_fwd_a", {30'd0, fwd_a}, {30'd0, exp_fwd(m_ex, m_ex.rs1, m_ex.u1)});
      chk("cyc_fwd_b", {30'd0, fwd_b}, {30'd0, exp_fwd(m_ex, m_ex.rs2, m_ex.u2)});
      chk("cyc_stall", {31'd0, stall}, {31'd0, !rst && (mem_wait || (m_lu() && !flush))});
      chk("cyc_bubble", {31'd0, bubble}, {31'd0, !rst && !mem_wait && (flush || m_lu())});
      if (!preload) chk("cyc_count", {16'd0, load_use_count}, m_cnt);
   end

   // ---------------- directed stimulus ----------------
   task automatic go(ins_t i, logic fl = 1'b0, logic mw = 1'b0);
      @(posedge clk);
      #1;
      cur = i; flush = fl; mem_wait = mw;
      #2;
   endtask

   task automatic drain();
      for (int k = 0; k < 3; k++) go('0);
   endtask

   initial begin
      rst = 1'b1;
      cur = ins_t'($urandom);
      flush = 1'b1; mem_wait = 1'b1;
      #3;
      chk("rst_fwd_a", {30'd0, fwd_a}, 0);
      chk("rst_fwd_b", {30'd0, fwd_b}, 0);
      chk("rst_stall", {31'd0, stall}, 0);
      chk("rst_bubble", {31'd0, bubble}, 0);
      chk("rst_count", {16'd0, load_use_count}, 0);
      #9;
      cur = '0; flush = 1'b0; mem_wait = 1'b0;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         go('0);
         chk("idle_fwd", {28'd0, fwd_a, fwd_b}, 0);
         chk("idle_stall", {31'd0, stall}, 0);
      end

      // EX/MEM forward
      go(alu(5, 1, 2));
      go(alu(6, 5, 7));
      chk("exmem_stall", {31'd0, stall}, 0);
      go('0);
      chk("exmem_fwd_a", {30'd0, fwd_a}, 32'h2);
      chk("exmem_fwd_b", {30'd0, fwd_b}, 32'h0);
      drain();

      // MEM/WB forward
      go(alu(5, 1, 2));
      go('0);
      go(alu(8, 5, 5));
      go('0);
      chk("memwb_fwd_a", {30'd0, fwd_a}, 32'h1);
      chk("memwb_fwd_b", {30'd0, fwd_b}, 32'h1);
      drain();

      // youngest producer wins
      go(alu(5, 1, 2));
      go(alu(5, 3, 4));
      go(alu(9, 5, 1));
      go('0);
      chk("prio_fwd_a", {30'd0, fwd_a}, 32'h2);
      drain();

      // three behind reads the register file
      go(alu(5, 1, 2));
      go('0);
      go('0);
      go(alu(9, 5, 5));
      go('0);
      chk("far_fwd", {28'd0, fwd_a, fwd_b}, 0);
      drain();

      // load-use
      go(ld(3, 2));
      go(alu(4, 3, 1));
      chk("lu_stall", {31'd0, stall}, 1);
      chk("lu_bubble", {31'd0, bubble}, 1);
      go(alu(4, 3, 1));
      chk("lu_stall_once", {31'd0, stall}, 0);
      chk("lu_count", {16'd0, load_use_count}, 1);
      go('0);
      chk("lu_fwd_a", {30'd0, fwd_a}, 32'h1);
      chk("lu_fwd_b", {30'd0, fwd_b}, 32'h0);
      drain();

      // x0 never stalls or forwards
      go(ld(0, 2));
      go(alu(6, 0, 0));
      chk("x0_stall", {31'd0, stall}, 0);
      go('0);
      chk("x0_fwd", {28'd0, fwd_a, fwd_b}, 0);
      drain();

      // flush in the hazard cycle
      go(ld(3, 2));
      go(alu(4, 3, 1), 1'b1);
      chk("fl_stall", {31'd0, stall}, 0);
      chk("fl_bubble", {31'd0, bubble}, 1);
      go('0);
      chk("fl_count", {16'd0, load_use_count}, 1);
      drain();

      // mem_wait over a pending load-use
      go(ld(3, 2));
      for (int k = 0; k < 3; k++) begin
         go(alu(4, 3, 1), 1'b0, 1'b1);
         chk("mw_stall", {31'd0, stall}, 1);
         chk("mw_bubble", {31'd0, bubble}, 0);
         chk("mw_count", {16'd0, load_use_count}, 1);
      end
      go(alu(4, 3, 1));
      chk("mw_hazard_stall", {31'd0, stall}, 1);
      chk("mw_hazard_bubble", {31'd0, bubble}, 1);
      go(alu(4, 3, 1));
      chk("mw_after_stall", {31'd0, stall}, 0);
      chk("mw_after_count", {16'd0, load_use_count}, 2);
      drain();

      // reset in the middle of a stall
      go(ld(3, 2));
      go(alu(4, 3, 1));
      chk("mid_pre_stall", {31'd0, stall}, 1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_stall", {31'd0, stall}, 0);
      chk("mid_rst_count", {16'd0, load_use_count}, 0);
      @(negedge clk);
      #1 rst = 1'b0;
      cur = '0;
      drain();

      // saturation from a preloaded counter
      go('0, 1'b0, 1'b1);
      preload = 1'b1;
      force dut.cnt_q = 16'hFFFD;
      #1 release dut.cnt_q;
      go('0, 1'b0, 1'b1);
      preload = 1'b0;
      chk("sat_preload", {16'd0, load_use_count}, 32'hFFFD);
      for (int k = 0; k < 8; k++) go(ld(3, 3));
      go('0);
      chk("sat_count", {16'd0, load_use_count}, 32'hFFFF);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
